bcd2bin: RTL and testbench

BCD2BIN -- requirements
Module: bcd2bin

---
 rtl/bcd2bin.sv | 107 ++++++++++
 tb/tb_bcd2bin.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/bcd2bin.sv
// Serial packed-BCD to binary converter using reverse double-dabble.
// One shift per SHIFT cycle; an input with a bad digit skips the shifting and reports err.
module bcd2bin #(
  parameter int DIGITS = 3,
  parameter int WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      bin,
  output logic                  err
);
  localparam int WW = 4*DIGITS + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WW-1:0]    work_q, work_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic             err_q, err_d;
  logic             err_pend_q, err_pend_d;
  logic [WW-1:0]    shifted;
  logic [WW-1:0]    step;
  logic [DIGITS-1:0] digit_bad;

  assign shifted            = work_q >> 1;
  assign step[WIDTH-1:0]    = shifted[WIDTH-1:0];

  // Each digit field is corrected on its own; no borrow crosses a field boundary.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [3:0] field;
    assign field                     = shifted[WIDTH+4*gi +: 4];
    assign step[WIDTH+4*gi +: 4]     = (field >= 4'd8) ? (field - 4'd3) : field;
    assign digit_bad[gi]             = (bcd[4*gi +: 4] > 4'd9);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    bin_d      = bin_q;
    err_d      = err_q;
    err_pend_d = err_pend_q;
    case (state_q)
      IDLE: begin
        // A rejected input spends one quiet cycle here before reporting, with start ignored.
        if (err_pend_q) begin
          err_pend_d = 1'b0;
          bin_d      = '0;
          err_d      = 1'b1;
          state_d    = DONE;
        end else if (start) begin
          work_d = {bcd, {WIDTH{1'b0}}};
          cnt_d  = '0;
          if (|digit_bad) begin
            err_pend_d = 1'b1;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (cnt_q == CW'(WIDTH)) begin
          bin_d   = work_q[WIDTH-1:0];
          err_d   = 1'b0;
          state_d = DONE;
        end else begin
          work_d = step;
          cnt_d  = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      work_q     <= '0;
      bin_q      <= '0;
      err_q      <= 1'b0;
      err_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      bin_q      <= bin_d;
      err_q      <= err_d;
      err_pend_q <= err_pend_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign bin  = bin_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd2bin.sv
// Self-checking bench for bcd2bin: directed cases plus random BCD words
// compared against a decimal-arithmetic reference model.
module tb_bcd2bin;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] bcd;
  logic        busy;
  logic        done;
  logic [9:0]  bin;
  logic        err;

  int n_vec = 0;
  int n_bad = 0;

  bcd2bin #(.DIGITS(3), .WIDTH(10)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bcd   (bcd),
    .busy  (busy),
    .done  (done),
    .bin   (bin),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain decimal weighting of the digits; {err, bin}.
  function automatic logic [10:0] model(input logic [11:0] b);
    int val = 0;
    int pw  = 1;
    bit bad = 0;
    for (int i = 0; i < 3; i++) begin
      int d = (b >> (4*i)) & 15;
      if (d > 9) bad = 1;
      val += d * pw;
      pw  *= 10;
    end
    if (bad) return {1'b1, 10'd0};
    return {1'b0, 10'(val)};
  endfunction

  task automatic wait_done(output int lat, output int busy_cnt, output bit got,
                           output logic [9:0] first_bin);
    lat = 0; busy_cnt = 0; got = 0; first_bin = '0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      lat++;
      if (k == 0) first_bin = bin;
      if (busy) busy_cnt++;
      if (done) got = 1;
    end
  endtask

  task automatic run_conv(input logic [11:0] b, input string tag);
    logic [10:0] e;
    logic [9:0]  prev_bin, first_bin;
    int lat, bc;
    bit got;
    e = model(b);
    @(negedge clk);
    prev_bin = bin;
    bcd = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, bc, got, first_bin);
    chk({tag, "_done_seen"}, 32'(got), 1);
    chk({tag, "_latency"},   32'(lat), e[10] ? 2 : 12);
    chk({tag, "_busy_cyc"},  32'(bc),  e[10] ? 0 : 11);
    chk({tag, "_bin_held"},  32'(first_bin), 32'(prev_bin));
    chk({tag, "_bin"},       32'(bin), 32'(e[9:0]));
    chk({tag, "_err"},       32'(err), 32'(e[10]));
    @(negedge clk);
    chk({tag, "_one_pulse"}, 32'(done), 0);
    $display("conv %s bcd=%h -> bin=%0d err=%0b lat=%0d", tag, b, bin, err, lat);
  endtask

  initial begin
    int t, last, pulses, dn, dn_t;
    logic [11:0] r;
    rst = 1'b0; start = 1'b0; bcd = '0;
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_bin",  32'(bin),  0);
    chk("rst_err",  32'(err),  0);
    @(negedge clk);
    rst = 1'b1;

    run_conv(12'h255, "h255");
    run_conv(12'h999, "h999");
    run_conv(12'h000, "h000");
    run_conv(12'h1A3, "h1A3");
    run_conv(12'h321, "h321");

    // Input changes and start pulses while converting must not disturb the result.
    @(negedge clk);
    bcd = 12'h042; start = 1'b1;
    @(posedge clk);
    #1 bcd = 12'h777;
    dn = 0; dn_t = 0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      start = (i < 8) ? ((i % 2) == 1) : 1'b0;
      if (done) begin dn++; dn_t = i; end
    end
    start = 1'b0;
    chk("h042_pulses",  32'(dn),   1);
    chk("h042_latency", 32'(dn_t), 12);
    chk("h042_bin",     32'(bin),  42);
    chk("h042_err",     32'(err),  0);
    $display("conv h042 with interference -> bin=%0d pulses=%0d", bin, dn);

    // Asynchronous reset in the middle of shifting.
    @(negedge clk);
    bcd = 12'h555; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_bin",  32'(bin),  0);
    chk("arst_err",  32'(err),  0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    dn = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("arst_no_done", 32'(dn), 0);
    $display("reset mid-shift -> bin=%0d done_pulses=%0d", bin, dn);
    run_conv(12'h100, "h100");

    // Start held high: back-to-back conversions.
    @(negedge clk);
    bcd = 12'h010; start = 1'b1;
    t = 0; last = -1; pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      t++;
      if (done) begin
        pulses++;
        chk("held_bin", 32'(bin), 10);
        if (last >= 0) chk("held_spacing", 32'(t - last), 13);
        $display("held pulse %0d at cycle %0d bin=%0d", pulses, t, bin);
        last = t;
      end
    end
    start = 1'b0;
    chk("held_pulses", 32'(pulses), 3);
    repeat (20) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      for (int d = 0; d < 3; d++) begin
        r[4*d +: 4] = (($urandom % 10) == 0) ? 4'($urandom_range(10, 15))
                                            : 4'($urandom_range(0, 9));
      end
      run_conv(r, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
